// File: rtl/pipeline_ctrl_pkg.sv
// ------------------------------------------------------------------
// pipeline_ctrl_pkg: shared types for the LC-3b pipeline sequencer.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_SEQ  = 2'd0,
      PC_FIX  = 2'd1,
      PC_HELD = 2'd2
   } lc3b_pcsel_t;

   typedef enum logic [0:0] {
      RUN           = 1'b0,
      REDIRECT_WAIT = 1'b1
   } pipe_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ------------------------------------------------------------------
// pipeline_ctrl_if: hazard inputs and stage-register controls.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic        icache_req;
   logic        icache_resp;
   logic        dcache_req;
   logic        dcache_resp;
   logic        load_use;
   logic        br_valid;
   logic        mispredict;

   logic        load_pc;
   lc3b_pcsel_t pc_sel;
   logic        load_target;
   logic        load_if_id;
   logic        load_id_ex;
   logic        load_ex_mem;
   logic        load_mem_wb;
   logic        bubble_if_id;
   logic        bubble_id_ex;
   logic        bubble_ex_mem;

   modport master (
      input  icache_req, icache_resp, dcache_req, dcache_resp,
             load_use, br_valid, mispredict,
      output load_pc, pc_sel, load_target,
             load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             bubble_if_id, bubble_id_ex, bubble_ex_mem
   );

   modport slave (
      output icache_req, icache_resp, dcache_req, dcache_resp,
             load_use, br_valid, mispredict,
      input  load_pc, pc_sel, load_target,
             load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             bubble_if_id, bubble_id_ex, bubble_ex_mem
   );

endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
// ------------------------------------------------------------------
// sat_counter: up-counter that sticks at its all-ones value.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_counter #(
   parameter int CW = 32
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          inc_i,
   output logic     [CW-1:0]  count_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CW{1'b1}})) begin
         count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ------------------------------------------------------------------
// pipeline_ctrl: stall/flush sequencer for the five-stage LC-3b pipe.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CW = 32
) (
   input  wire logic          clk,
   input  wire logic          reset,
   pipeline_ctrl_if.master    bus,
   output logic     [CW-1:0]  stall_cycles_o,
   output logic     [CW-1:0]  branch_count_o,
   output logic     [CW-1:0]  mispredict_count_o
);

   pipe_ctrl_state_t state_q;
   pipe_ctrl_state_t state_d;

   logic dstall;
   logic istall;
   logic mem_adv;
   logic mp;

   assign dstall  = bus.dcache_req & ~bus.dcache_resp;
   assign istall  = bus.icache_req & ~bus.icache_resp;
   assign mem_adv = ~dstall;
   assign mp      = bus.br_valid & bus.mispredict & mem_adv;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      bus.load_pc       = 1'b0;
      bus.pc_sel        = PC_SEQ;
      bus.load_target   = 1'b0;
      bus.load_if_id    = 1'b0;
      bus.load_id_ex    = 1'b0;
      bus.load_ex_mem   = 1'b0;
      bus.load_mem_wb   = 1'b0;
      bus.bubble_if_id  = 1'b0;
      bus.bubble_id_ex  = 1'b0;
      bus.bubble_ex_mem = 1'b0;

      if (reset || dstall) begin
         state_d = state_q;
      end else if (state_q == REDIRECT_WAIT) begin
         // Anything fetched while waiting is squashed; the held target replaces it.
         bus.load_if_id   = 1'b1;
         bus.load_id_ex   = 1'b1;
         bus.load_ex_mem  = 1'b1;
         bus.load_mem_wb  = 1'b1;
         bus.bubble_if_id = 1'b1;
         if (bus.icache_resp) begin
            bus.load_pc = 1'b1;
            bus.pc_sel  = PC_HELD;
            state_d     = RUN;
         end
      end else if (mp) begin
         bus.load_if_id    = 1'b1;
         bus.load_id_ex    = 1'b1;
         bus.load_ex_mem   = 1'b1;
         bus.load_mem_wb   = 1'b1;
         bus.bubble_if_id  = 1'b1;
         bus.bubble_id_ex  = 1'b1;
         bus.bubble_ex_mem = 1'b1;
         if (istall) begin
            bus.load_target = 1'b1;
            state_d         = REDIRECT_WAIT;
         end else begin
            bus.load_pc = 1'b1;
            bus.pc_sel  = PC_FIX;
         end
      end else if (istall) begin
         bus.load_if_id   = 1'b1;
         bus.bubble_if_id = 1'b1;
         bus.load_id_ex   = 1'b1;
         bus.load_ex_mem  = 1'b1;
         bus.load_mem_wb  = 1'b1;
      end else if (bus.load_use) begin
         bus.load_id_ex   = 1'b1;
         bus.bubble_id_ex = 1'b1;
         bus.load_ex_mem  = 1'b1;
         bus.load_mem_wb  = 1'b1;
      end else begin
         bus.load_pc     = 1'b1;
         bus.load_if_id  = 1'b1;
         bus.load_id_ex  = 1'b1;
         bus.load_ex_mem = 1'b1;
         bus.load_mem_wb = 1'b1;
      end
   end

   sat_counter #(.CW(CW)) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (~reset & ~bus.load_pc),
      .count_o (stall_cycles_o)
   );

   sat_counter #(.CW(CW)) u_branch_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (bus.br_valid & mem_adv),
      .count_o (branch_count_o)
   );

   sat_counter #(.CW(CW)) u_mispredict_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (mp),
      .count_o (mispredict_count_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ------------------------------------------------------------------
// tb_pipeline_ctrl: directed vectors with a queued scoreboard.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int CW = 4;

   // {load_pc, pc_sel, load_target, load if/id/ex/mem/wb, bubble if/id/ex}
   localparam logic [10:0] RUNV = 11'b1_00_0_1111_000;
   localparam logic [10:0] DST  = 11'b0_00_0_0000_000;
   localparam logic [10:0] MPF  = 11'b1_01_0_1111_111;
   localparam logic [10:0] MPW  = 11'b0_00_1_1111_111;
   localparam logic [10:0] RWW  = 11'b0_00_0_1111_100;
   localparam logic [10:0] RWH  = 11'b1_10_0_1111_100;
   localparam logic [10:0] IST  = 11'b0_00_0_1111_100;
   localparam logic [10:0] LU   = 11'b0_00_0_0111_010;

   typedef struct {
      string       name;
      logic [10:0] ctrl;
      int          sc;
      int          bc;
      int          mc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [CW-1:0] stall_cycles;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(.CW(CW)) dut (
      .clk                (clk),
      .reset              (reset),
      .bus                (bus),
      .stall_cycles_o     (stall_cycles),
      .branch_count_o     (branch_count),
      .mispredict_count_o (mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic ireq, input logic iresp,
                       input logic dreq, input logic dresp, input logic lu,
                       input logic bv, input logic mpr, input logic [10:0] c,
                       input int sc, input int bc, input int mc, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset           = rst;
      bus.icache_req  = ireq;
      bus.icache_resp = iresp;
      bus.dcache_req  = dreq;
      bus.dcache_resp = dresp;
      bus.load_use    = lu;
      bus.br_valid    = bv;
      bus.mispredict  = mpr;
      e.name = nm;
      e.ctrl = c;
      e.sc   = sc;
      e.bc   = bc;
      e.mc   = mc;
      sb_q.push_back(e);
   endtask

   // Monitor: compares the combinational controls and counters mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            exp_t e;
            logic [10:0] got;
            e = sb_q.pop_front();
            got = {bus.load_pc, 2'(bus.pc_sel), bus.load_target,
                   bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb,
                   bus.bubble_if_id, bus.bubble_id_ex, bus.bubble_ex_mem};
            total++;
            if (got !== e.ctrl || int'(stall_cycles) != e.sc ||
                int'(branch_count) != e.bc || int'(mispredict_count) != e.mc) begin
               bad++;
               $display("FAIL %s: got ctrl=%b sc=%0d bc=%0d mc=%0d, expected ctrl=%b sc=%0d bc=%0d mc=%0d",
                        e.name, got, stall_cycles, branch_count, mispredict_count,
                        e.ctrl, e.sc, e.bc, e.mc);
            end
         end
      end
   end

   initial begin
      int drain;
      reset           = 1'b1;
      bus.icache_req  = 1'b0;
      bus.icache_resp = 1'b0;
      bus.dcache_req  = 1'b0;
      bus.dcache_resp = 1'b0;
      bus.load_use    = 1'b0;
      bus.br_valid    = 1'b0;
      bus.mispredict  = 1'b0;

      step(1, 0,0, 0,0, 0, 0,0, DST, 0, 0, 0, "reset");
      for (int i = 0; i < 10; i++)
         step(0, 0,0, 0,0, 0, 0,0, RUNV, 0, 0, 0, "plain");

      // D-cache miss with a mispredict held until the response cycle
      for (int i = 0; i < 4; i++)
         step(0, 0,0, 1,0, 0, 1,1, DST, i, 0, 0, "dmiss");
      step(0, 0,0, 1,1, 0, 1,1, MPF, 4, 0, 0, "dresp_mp");
      step(0, 0,0, 0,0, 0, 0,0, RUNV, 4, 1, 1, "after_dmiss");

      step(0, 0,0, 0,0, 1, 0,0, LU, 4, 1, 1, "load_use");
      step(0, 0,0, 0,0, 0, 0,0, RUNV, 5, 1, 1, "after_lu");

      step(0, 0,0, 0,0, 0, 1,1, MPF, 5, 1, 1, "mp_idle");
      step(0, 0,0, 0,0, 0, 0,0, RUNV, 5, 2, 2, "after_mp");

      // Mispredict while fetch outstanding, then wait out the I-cache
      step(0, 1,0, 0,0, 0, 1,1, MPW, 5, 2, 2, "mp_fetch");
      step(0, 1,0, 0,0, 1, 0,0, RWW, 6, 3, 3, "rw_lu_ign");
      step(0, 1,0, 0,0, 0, 0,0, RWW, 7, 3, 3, "rw_wait");
      step(0, 1,1, 1,0, 0, 0,0, DST, 8, 3, 3, "rw_dstall");
      step(0, 1,1, 0,0, 0, 0,0, RWH, 9, 3, 3, "rw_held");
      step(0, 0,0, 0,0, 0, 0,0, RUNV, 9, 3, 3, "back_run");

      step(0, 1,0, 0,0, 0, 0,0, IST, 9, 3, 3, "istall");
      step(0, 1,0, 0,0, 1, 0,0, IST, 10, 3, 3, "istall_lu");
      step(0, 1,1, 0,0, 0, 0,0, RUNV, 11, 3, 3, "iresp");
      step(0, 1,1, 1,1, 0, 0,0, RUNV, 11, 3, 3, "both_resp");

      // Reset in the middle of a redirect wait
      step(0, 1,0, 0,0, 0, 1,1, MPW, 11, 3, 3, "mp_fetch2");
      step(0, 1,0, 0,0, 0, 0,0, RWW, 12, 4, 4, "rw_wait2");
      step(1, 1,0, 0,0, 0, 0,0, DST, 13, 4, 4, "reset_mid");
      step(0, 0,0, 0,0, 0, 0,0, RUNV, 0, 0, 0, "post_reset");

      for (int i = 0; i < 20; i++)
         step(0, 0,0, 0,0, 0, 1,1, MPF, 0, (i > 15) ? 15 : i, (i > 15) ? 15 : i, "sat_mp");
      step(0, 0,0, 0,0, 0, 0,0, RUNV, 0, 15, 15, "sat_mp_hold");
      for (int i = 0; i < 20; i++)
         step(0, 0,0, 0,0, 1, 0,0, LU, (i > 15) ? 15 : i, 15, 15, "sat_stall");
      step(0, 0,0, 0,0, 0, 0,0, RUNV, 15, 15, 15, "sat_stall_hold");

      drain = 0;
      while (sb_q.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      if (sb_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, required 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage LC-3b pipeline. It drives the load and bubble-insert controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves I-cache stalls, D-cache stalls, load-use hazards and MEM-stage branch mispredicts into one consistent per-cycle control set. It also owns the pending-redirect state used when a mispredict resolves while an I-fetch is still outstanding, and keeps saturating performance counters.

## Interface
- CW, 32, width of each performance counter

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- icache_req  in  1  IF fetch outstanding this cycle
- icache_resp  in  1  I-cache returns instruction this cycle
- dcache_req  in  1  MEM-stage instruction accesses memory
- dcache_resp  in  1  D-cache completes access this cycle
- load_use  in  1  ID instruction depends on EX-stage load (comb, from hazard detect)
- br_valid  in  1  MEM stage holds a resolved conditional branch
- mispredict  in  1  MEM branch outcome ≠ prediction (qualified by br_valid)
- load_pc  out  1  PC register enable
- pc_sel  out  lc3b_pcsel_t (2)  PC_SEQ=0 predicted/sequential, PC_FIX=1 correction from MEM, PC_HELD=2 latched target
- load_target  out  1  capture MEM correction target into held-target register
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register enables
- bubble_if_id, bubble_id_ex, bubble_ex_mem  out  1 each  when set with matching load, register captures all-zero control word
- stall_cycles, branch_count, mispredict_count  out  CW each  performance counters

## Operation
- States: RUN, REDIRECT_WAIT. Reset → RUN.
- Derived terms: dstall = dcache_req & ~dcache_resp; istall = icache_req & ~icache_resp; mem_adv = ~dstall; mp = br_valid & mispredict & mem_adv.
- Priority, evaluated every cycle, highest first:
  1. dstall: all load_* = 0, all bubbles = 0. Mispredict is not acted on and the state is held.
  2. mp in RUN, ~istall: all four loads = 1; bubble_if_id = bubble_id_ex = bubble_ex_mem = 1; load_pc = 1; pc_sel = PC_FIX. Stay in RUN.
  3. mp in RUN, istall: same loads and bubbles; load_pc = 0; load_target = 1; go to REDIRECT_WAIT.
  4. REDIRECT_WAIT (no dstall): all four loads = 1; bubble_if_id = 1. While icache_resp = 0: load_pc = 0. When icache_resp = 1: load_pc = 1, pc_sel = PC_HELD, go to RUN. The fetched instruction is discarded via the bubble.
  5. istall in RUN: load_pc = 0; load_if_id = 1 with bubble_if_id = 1; the other three loads = 1.
  6. load_use in RUN: load_pc = 0; load_if_id = 0; load_id_ex = 1 with bubble_id_ex = 1; load_ex_mem = load_mem_wb = 1.
  7. Otherwise: all loads = 1, load_pc = 1, pc_sel = PC_SEQ, no bubbles.
- load_use is ignored whenever mp is set or the state is REDIRECT_WAIT, because the dependent instruction is squashed.
- A mispredict arriving while in REDIRECT_WAIT cannot occur, since the MEM stage holds bubbles. If it does arrive, it is ignored.
- Counters saturate at 2^CW−1 and never wrap:
  - stall_cycles: +1 on every cycle with load_pc = 0 outside reset.
  - branch_count: +1 on br_valid & mem_adv.
  - mispredict_count: +1 on mp.

## Timing
- All load_*, bubble_*, pc_sel and load_target outputs are combinational from the state and the current inputs. No added latency.
- State and counters update on posedge clk.
- During reset: all load_*/bubble_*/load_target = 0, pc_sel = PC_SEQ, state → RUN, counters → 0 on the edge.
- Reset asserted in REDIRECT_WAIT discards the pending redirect.
- Outside reset, the only path from REDIRECT_WAIT back to RUN is icache_resp in a non-dstall cycle.
- dcache_resp and icache_resp in the same cycle resolve as no stall on either side.

## Structure
- lc3b_types gains lc3b_pcsel_t (PC_SEQ, PC_FIX, PC_HELD) and pipe_ctrl_state_t (RUN, REDIRECT_WAIT).
- One sub-module, sat_counter #(CW): clk, reset, inc, count. It is instantiated three times.
- The held-target register lives in the datapath, enabled by load_target.

## Test plan
- Plain flow: no hazards for 10 cycles → all loads = 1 every cycle, pc_sel = PC_SEQ, stall_cycles = 0.
- D-cache miss: dcache_req = 1, dcache_resp low 4 cycles then high → all loads = 0 for 4 cycles, then all = 1. stall_cycles = 4. A concurrent mp is counted only on the resp cycle.
- Load-use: load_use = 1 one cycle → load_pc = 0, load_if_id = 0, bubble_id_ex = 1. stall_cycles = 1.
- Mispredict, idle I-cache: br_valid = mispredict = 1 → three bubbles, pc_sel = PC_FIX, load_pc = 1. branch_count = 1, mispredict_count = 1.
- Mispredict during fetch: istall for 3 cycles after mp → load_target = 1 on the mp cycle, load_pc = 0 for 3 cycles, then pc_sel = PC_HELD with bubble_if_id = 1. State returns to RUN. Repeat with reset mid-wait → state RUN and counters 0 after the reset edge.
- Saturation with CW = 4: 20 mispredicts → mispredict_count holds at 15.
